// File: rtl/lsu_pkg.sv
// Shared load/store unit types: FSM states, RV64 funct3 encodings, fault codes.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [1:0] FAULT_OK      = 2'b00;
  localparam logic [1:0] FAULT_ALIGN   = 2'b01;
  localparam logic [1:0] FAULT_RANGE   = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b11;

  // Low address bits that must be zero for an access of size 1 << sz.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// EX-stage request / completion bundle between the pipeline and the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_fault;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends a load lane from a doubleword and
// merges store bytes into a doubleword for read-modify-write.
module lsu_lane_align (
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] load_data,
  output logic [63:0] merged_data
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] lane_mask;
  logic [63:0] byte_mask;
  logic        sign;

  assign shamt = {offset, 3'b000};

  always_comb begin
    shifted   = rdata >> shamt;
    lane_mask = '1;
    sign      = 1'b0;
    case (funct3[1:0])
      2'd0: begin lane_mask = 64'h0000_0000_0000_00FF; sign = shifted[7];  end
      2'd1: begin lane_mask = 64'h0000_0000_0000_FFFF; sign = shifted[15]; end
      2'd2: begin lane_mask = 64'h0000_0000_FFFF_FFFF; sign = shifted[31]; end
      default: begin lane_mask = '1; sign = shifted[63]; end
    endcase
    // funct3[2] selects the unsigned variants.
    load_data = shifted & lane_mask;
    if (!funct3[2] && sign)
      load_data = load_data | ~lane_mask;
    byte_mask   = lane_mask << shamt;
    merged_data = (rdata & ~byte_mask) | ((wdata << shamt) & byte_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV64 load/store unit: fault check on accept, then load,
// direct doubleword write, or read-modify-write for narrow stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 64
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   lsu,
  output logic [63:0]        Mem_Addr,
  output logic [63:0]        Write_Data,
  output logic               MemWrite,
  output logic               MemRead,
  input  logic [63:0]        Read_Data
);

  localparam int AW = $clog2(MEM_BYTES);

  state_t      state_q, state_d;
  logic [63:0] addr_q;
  logic [2:0]  funct3_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [1:0]  fault_q;
  logic [1:0]  req_fault;
  logic        accept;
  logic [63:0] load_data;
  logic [63:0] merged_data;

  always_comb begin
    req_fault = FAULT_OK;
    if (lsu.req_funct3 == F3_BAD || (lsu.req_write && lsu.req_funct3[2]))
      req_fault = FAULT_ILLEGAL;
    else if ((lsu.req_addr[2:0] & align_mask(lsu.req_funct3[1:0])) != 3'b000)
      req_fault = FAULT_ALIGN;
    else if ((lsu.req_addr >> AW) != 64'd0)
      req_fault = FAULT_RANGE;
  end

  assign accept = lsu.req_valid && lsu.req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    lsu.req_ready  = 1'b0;
    lsu.resp_valid = 1'b0;
    lsu.resp_rdata = '0;
    lsu.resp_fault = FAULT_OK;
    Mem_Addr       = '0;
    Write_Data     = '0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Reset is asynchronous to this path, so ready is masked directly.
        lsu.req_ready = !reset;
        if (lsu.req_valid && !reset) begin
          if (req_fault != FAULT_OK)        state_d = S_RESP;
          else if (!lsu.req_write)          state_d = S_LOAD;
          else if (lsu.req_funct3 == F3_D)  state_d = S_WRITE;
          else                              state_d = S_RMW_READ;
        end
      end
      S_LOAD: begin
        MemRead  = 1'b1;
        Mem_Addr = {addr_q[63:3], 3'b000};
        state_d  = S_RESP;
      end
      S_RMW_READ: begin
        MemRead  = 1'b1;
        Mem_Addr = {addr_q[63:3], 3'b000};
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        MemWrite   = 1'b1;
        Mem_Addr   = {addr_q[63:3], 3'b000};
        Write_Data = wdata_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        lsu.resp_valid = 1'b1;
        lsu.resp_rdata = rdata_q;
        lsu.resp_fault = fault_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= FAULT_OK;
    end else begin
      if (accept) begin
        addr_q   <= lsu.req_addr;
        funct3_q <= lsu.req_funct3;
        wdata_q  <= lsu.req_wdata;
        rdata_q  <= '0;
        fault_q  <= req_fault;
      end
      if (state_q == S_LOAD)     rdata_q <= load_data;
      if (state_q == S_RMW_READ) wdata_q <= merged_data;
    end
  end

  lsu_lane_align u_lane_align (
    .rdata       (Read_Data),
    .wdata       (wdata_q),
    .offset      (addr_q[2:0]),
    .funct3      (funct3_q),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

  localparam int MEM_BYTES = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] Mem_Addr, Write_Data, Read_Data;
  logic        MemWrite, MemRead;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .lsu        (bus),
    .Mem_Addr   (Mem_Addr),
    .Write_Data (Write_Data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Read_Data  (Read_Data)
  );

  always #5 clk = ~clk;

  // Data memory stand-in: combinational doubleword read, write on rising edge.
  bit [7:0] mem [MEM_BYTES];
  int       wr_cnt = 0;
  int       rd_cnt = 0;
  logic [63:0] wr_addr = '0;

  always_comb begin
    int base;
    Read_Data = '0;
    base = int'(Mem_Addr[31:0]) & (MEM_BYTES - 8);
    for (int i = 0; i < 8; i++) Read_Data[8*i +: 8] = mem[base + i];
  end

  always @(posedge clk) begin
    int base;
    base = int'(Mem_Addr[31:0]) & (MEM_BYTES - 8);
    if (MemRead) rd_cnt++;
    if (MemWrite) begin
      wr_cnt++;
      wr_addr = Mem_Addr;
      for (int i = 0; i < 8; i++) mem[base + i] = Write_Data[8*i +: 8];
    end
  end

  // Reference model state.
  bit [7:0] ref_mem [MEM_BYTES];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] model_fault(input logic w, input logic [2:0] f3, input logic [63:0] a);
    if (f3 == 3'b111 || (w && f3 >= 3'b100)) return 2'b11;
    if (a % 64'(size_of(f3)) != 0) return 2'b01;
    if (a >= 64'(MEM_BYTES)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
    logic [63:0] v;
    int sz;
    sz = size_of(f3);
    v = '0;
    for (int i = 0; i < sz; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (f3 < 3'b100 && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    return v;
  endfunction

  function automatic logic [63:0] mem_dword(input int a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[a + i];
    return v;
  endfunction

  task automatic xact(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                      output int lat, output logic [63:0] rd, output logic [1:0] flt);
    bit got;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.req_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) chk("accept_timeout", 64'(got), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1;
    rd  = 'x;
    flt = 'x;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = n;
        rd  = bus.resp_rdata;
        flt = bus.resp_fault;
        break;
      end
    end
  endtask

  // Issues one request, checks it against the model, and updates the model.
  task automatic run(input string tag, input logic w, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd, output logic [63:0] rd);
    logic [1:0]  ef, flt;
    logic [63:0] er;
    int el, lat, w0, r0, ew, erd;
    ef  = model_fault(w, f3, a);
    er  = (ef == 2'b00 && !w) ? model_load(f3, a) : 64'd0;
    el  = (ef != 2'b00) ? 1 : (!w || f3 == 3'b011) ? 2 : 3;
    ew  = (ef == 2'b00 && w) ? 1 : 0;
    erd = (ef == 2'b00 && !(w && f3 == 3'b011)) ? 1 : 0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    xact(w, f3, a, wd, lat, rd, flt);
    chk({tag, "_latency"}, 64'(lat), 64'(el));
    chk({tag, "_fault"}, 64'(flt), 64'(ef));
    chk({tag, "_rdata"}, rd, er);
    chk({tag, "_memwrite_cycles"}, 64'(wr_cnt - w0), 64'(ew));
    chk({tag, "_memread_cycles"}, 64'(rd_cnt - r0), 64'(erd));
    if (ew == 1) begin
      chk({tag, "_write_addr"}, wr_addr, a & ~64'd7);
      for (int i = 0; i < size_of(f3); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    end
  endtask

  initial begin
    logic [63:0] rd, snap, r1, r2;
    logic [63:0] a;
    logic [2:0]  f3;
    logic        w;
    int resp1, rdy2, lat;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    reset = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("reset_resp_rdata", bus.resp_rdata, 64'd0);
    chk("reset_mem_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
    chk("reset_mem_addr", Mem_Addr, 64'd0);
    reset = 1'b0;
    #1 chk("ready_after_reset", 64'(bus.req_ready), 64'd1);

    run("sd8", 1'b1, 3'b011, 64'h8, 64'h1122334455667788, rd);
    chk("sd8_mem", mem_dword(8), 64'h1122334455667788);
    run("ld8", 1'b0, 3'b011, 64'h8, 64'd0, rd);
    chk("ld8_value", rd, 64'h1122334455667788);

    run("sbB", 1'b1, 3'b000, 64'hB, 64'h80, rd);
    chk("sbB_mem", mem_dword(8), 64'h1122334480667788);
    run("lbB", 1'b0, 3'b000, 64'hB, 64'd0, rd);
    chk("lbB_value", rd, 64'hFFFFFFFFFFFFFF80);
    run("lbuB", 1'b0, 3'b100, 64'hB, 64'd0, rd);
    chk("lbuB_value", rd, 64'h80);

    run("lh3_misaligned", 1'b0, 3'b001, 64'h3, 64'd0, rd);
    run("ld40_range", 1'b0, 3'b011, 64'h40, 64'd0, rd);
    run("f3_111_illegal", 1'b0, 3'b111, 64'h0, 64'd0, rd);
    run("sbu_illegal", 1'b1, 3'b100, 64'h0, 64'd0, rd);

    run("sw4", 1'b1, 3'b010, 64'h4, 64'h80000001, rd);
    run("lw4", 1'b0, 3'b010, 64'h4, 64'd0, rd);
    chk("lw4_value", rd, 64'hFFFFFFFF80000001);
    run("lwu4", 1'b0, 3'b110, 64'h4, 64'd0, rd);
    chk("lwu4_value", rd, 64'h0000000080000001);

    // Reset pulsed while a narrow store is in its read phase.
    snap = mem_dword(16);
    resp1 = wr_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 64'h10;
    bus.req_wdata  = 64'hDEADBEEF;
    chk("rst_rmw_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_rmw_memread", 64'(MemRead), 64'd1);
    reset = 1'b1;
    #1 chk("rst_rmw_strobes_in_reset", {62'd0, MemRead, MemWrite}, 64'd0);
    @(negedge clk);
    chk("rst_rmw_ready_in_reset", 64'(bus.req_ready), 64'd0);
    reset = 1'b0;
    #1 chk("rst_rmw_ready_after", 64'(bus.req_ready), 64'd1);
    repeat (5) @(negedge clk);
    chk("rst_rmw_no_write", 64'(wr_cnt - resp1), 64'd0);
    chk("rst_rmw_mem_unchanged", mem_dword(16), snap);

    // Back-to-back loads with req_valid held high.
    r1 = model_load(3'b010, 64'hC);
    r2 = model_load(3'b010, 64'h4);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 64'hC;
    chk("b2b_first_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_addr = 64'h4;
    resp1 = -1;
    rdy2  = -1;
    rd    = 'x;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus.resp_valid && resp1 < 0) begin
        resp1 = n;
        rd    = bus.resp_rdata;
      end
      if (bus.req_ready) begin
        rdy2 = n;
        break;
      end
    end
    chk("b2b_first_resp_cycle", 64'(resp1), 64'd2);
    chk("b2b_first_rdata", rd, r1);
    chk("b2b_second_accept_cycle", 64'(rdy2), 64'd3);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = n;
        rd  = bus.resp_rdata;
        break;
      end
    end
    chk("b2b_second_latency", 64'(lat), 64'd2);
    chk("b2b_second_rdata", rd, r2);

    // Randomized mix against the reference model.
    for (int k = 0; k < 80; k++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 64'($urandom_range(0, MEM_BYTES + 15));
      if ($urandom_range(0, 2) != 0) a = a & ~64'(size_of(f3) - 1);
      if ($urandom_range(0, 11) == 0) a = a | 64'h0000_0100_0000_0000;
      run("rand", w, f3, a, {$urandom, $urandom}, rd);
    end
    for (int i = 0; i < MEM_BYTES; i += 8)
      chk("final_mem_dword", mem_dword(i), {ref_mem[i+7], ref_mem[i+6], ref_mem[i+5], ref_mem[i+4],
                                            ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
